// File: rtl/lcd_pkg.sv
// Shared LCD types: arbiter state encoding, 9-bit writer word, idle word.
package lcd_pkg;

  typedef enum logic [4:0] {
    ST_INIT = 5'b00001,
    ST_IDLE = 5'b00010,
    ST_A    = 5'b00100,
    ST_B    = 5'b01000,
    ST_GAP  = 5'b10000
  } arb_state_t;

  // is_data = 1 selects the data register of the panel, 0 a command
  typedef struct packed {
    logic       is_data;
    logic [7:0] val;
  } lcd_word_t;

  localparam lcd_word_t DATA_IDLE = 9'h000;

endpackage

// File: rtl/lcd_arb_wdog.sv
// Grant watchdog: counts owned cycles without wr_done, flags expiry.
module lcd_arb_wdog #(
  parameter int unsigned WDOG_CYCLES = 23'd5_000_000
) (
  input  logic sys_clk_50MHz,
  input  logic sys_rst_n,
  input  logic run,
  input  logic kick,
  output logic expire
);
  localparam int W = $clog2(WDOG_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(WDOG_CYCLES - 1);

  logic [W-1:0] cnt;

  // held at zero outside a grant, so every new grant starts from a clean count
  assign expire = run && !kick && (cnt == LAST);

  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n)
    if (!sys_rst_n)                cnt <= '0;
    else if (!run || kick || expire) cnt <= '0;
    else                           cnt <= cnt + 1'b1;

endmodule

// File: rtl/lcd_wr_arbiter.sv
// LCD writer arbiter: init sequencer first, then round-robin A/B bursts.
// Optional grant watchdog enabled by defining LCD_ARB_WDOG_EN.
module lcd_wr_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned WDOG_CYCLES = 23'd5_000_000
) (
  input  logic      sys_clk_50MHz,
  input  logic      sys_rst_n,
  input  logic      init_en,
  input  lcd_word_t init_data,
  input  logic      init_done,
  input  logic      a_en,
  input  lcd_word_t a_data,
  input  logic      b_en,
  input  lcd_word_t b_data,
  input  logic      wr_done,
  output logic      lcd_en,
  output lcd_word_t lcd_data,
  output logic      a_wr_done,
  output logic      b_wr_done,
  output logic      a_gnt,
  output logic      b_gnt,
  output logic      init_wr_done,
  output logic      arb_err
);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  arb_state_t    state, nxt;
  logic [GW-1:0] gap_cnt;
  logic          init_done_q, last_a;
  logic          a_req, b_req, wdog_exp;

`ifdef LCD_ARB_WDOG_EN
  logic in_gnt, blk_a, blk_b;

  assign in_gnt = (state == ST_A) || (state == ST_B);

  lcd_arb_wdog #(.WDOG_CYCLES(WDOG_CYCLES)) u_wdog (
    .sys_clk_50MHz (sys_clk_50MHz),
    .sys_rst_n     (sys_rst_n),
    .run           (in_gnt),
    .kick          (wr_done),
    .expire        (wdog_exp)
  );

  // a revoked requester must release x_en before it counts as requesting again
  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n)
    if (!sys_rst_n) begin
      blk_a <= 1'b0;
      blk_b <= 1'b0;
    end else begin
      if (state == ST_A && wdog_exp) blk_a <= 1'b1;
      else if (!a_en)                blk_a <= 1'b0;
      if (state == ST_B && wdog_exp) blk_b <= 1'b1;
      else if (!b_en)                blk_b <= 1'b0;
    end

  assign a_req = a_en & ~blk_a;
  assign b_req = b_en & ~blk_b;
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
  assign wdog_exp    = 1'b0;
  assign a_req       = a_en;
  assign b_req       = b_en;
`endif

  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state       <= ST_INIT;
      gap_cnt     <= '0;
      init_done_q <= 1'b0;
      last_a      <= 1'b0;
    end else begin
      state <= nxt;
      if (state == ST_INIT && init_done) init_done_q <= 1'b1;
      if (state != ST_GAP)            gap_cnt <= '0;
      else if (gap_cnt != GAP_LAST)   gap_cnt <= gap_cnt + 1'b1;
      if (state == ST_A && nxt == ST_GAP)      last_a <= 1'b1;
      else if (state == ST_B && nxt == ST_GAP) last_a <= 1'b0;
    end

  always_comb begin
    nxt          = state;
    lcd_en       = 1'b0;
    lcd_data     = DATA_IDLE;
    a_wr_done    = 1'b0;
    b_wr_done    = 1'b0;
    init_wr_done = 1'b0;
    a_gnt        = 1'b0;
    b_gnt        = 1'b0;
    arb_err      = 1'b0;
    case (state)
      ST_INIT: begin
        lcd_en       = init_en;
        lcd_data     = init_data;
        init_wr_done = wr_done;
        if (init_done || init_done_q) nxt = ST_GAP;
      end
      ST_IDLE: begin
        if (a_req && (!b_req || !last_a)) nxt = ST_A;
        else if (b_req)                   nxt = ST_B;
      end
      ST_A: begin
        a_gnt     = 1'b1;
        lcd_en    = a_en;
        lcd_data  = a_data;
        a_wr_done = wr_done;
        arb_err   = wdog_exp;
        if (!a_en || wdog_exp) nxt = ST_GAP;
      end
      ST_B: begin
        b_gnt     = 1'b1;
        lcd_en    = b_en;
        lcd_data  = b_data;
        b_wr_done = wr_done;
        arb_err   = wdog_exp;
        if (!b_en || wdog_exp) nxt = ST_GAP;
      end
      ST_GAP:  if (gap_cnt == GAP_LAST) nxt = ST_IDLE;
      default: nxt = ST_INIT;
    endcase
    // outputs drop the moment reset asserts, not at the next edge
    if (!sys_rst_n) begin
      lcd_en       = 1'b0;
      lcd_data     = DATA_IDLE;
      a_wr_done    = 1'b0;
      b_wr_done    = 1'b0;
      init_wr_done = 1'b0;
      a_gnt        = 1'b0;
      b_gnt        = 1'b0;
      arb_err      = 1'b0;
    end
  end

endmodule

// File: tb/tb_lcd_wr_arbiter.sv
// Self-checking bench for lcd_wr_arbiter: directed scenarios plus random traffic.
module tb_lcd_wr_arbiter;
  localparam int GAP = 4;
  localparam int WD  = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       init_en, init_done, a_en, b_en, wr_done;
  logic [8:0] init_data, a_data, b_data;
  logic       lcd_en, a_wr_done, b_wr_done, a_gnt, b_gnt, init_wr_done, arb_err;
  logic [8:0] lcd_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lcd_wr_arbiter #(.GAP_CYCLES(GAP), .WDOG_CYCLES(WD)) dut (
    .sys_clk_50MHz (clk),
    .sys_rst_n     (rst_n),
    .init_en       (init_en),
    .init_data     (init_data),
    .init_done     (init_done),
    .a_en          (a_en),
    .a_data        (a_data),
    .b_en          (b_en),
    .b_data        (b_data),
    .wr_done       (wr_done),
    .lcd_en        (lcd_en),
    .lcd_data      (lcd_data),
    .a_wr_done     (a_wr_done),
    .b_wr_done     (b_wr_done),
    .a_gnt         (a_gnt),
    .b_gnt         (b_gnt),
    .init_wr_done  (init_wr_done),
    .arb_err       (arb_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    init_en = 0; init_done = 0; a_en = 0; b_en = 0; wr_done = 0;
    init_data = '0; a_data = '0; b_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clr_in();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  // leaves the bench in the first idle cycle after init
  task automatic do_init();
    tick();
    init_done = 1;
    repeat (GAP + 1) tick();
  endtask

  task automatic test_reset();
    rst_n = 0; init_en = 1; a_en = 1; b_en = 1; wr_done = 1; init_data = 9'h1A5;
    #3;
    checks++; if (lcd_en !== 1'b0) begin errors++; $display("FAIL rst_lcd_en: got %b want 0", lcd_en); end
    checks++; if (lcd_data !== 9'h000) begin errors++; $display("FAIL rst_lcd_data: got %h want 000", lcd_data); end
    checks++; if ({a_gnt, b_gnt} !== 2'b00) begin errors++; $display("FAIL rst_gnt: got %b want 00", {a_gnt, b_gnt}); end
    checks++; if ({a_wr_done, b_wr_done, init_wr_done} !== 3'b000) begin
      errors++; $display("FAIL rst_done: got %b want 000", {a_wr_done, b_wr_done, init_wr_done}); end
    checks++; if (arb_err !== 1'b0) begin errors++; $display("FAIL rst_arb_err: got %b want 0", arb_err); end
    @(posedge clk);
    #1 rst_n = 1;
    #3;
    checks++; if (lcd_en !== 1'b1 || lcd_data !== 9'h1A5 || a_gnt !== 1'b0) begin
      errors++; $display("FAIL rst_init_owner: got en=%b data=%h agnt=%b want en=1 data=1a5 agnt=0", lcd_en, lcd_data, a_gnt); end
    clr_in();
  endtask

  task automatic test_init_ownership();
    int k;
    bit bad;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick();
      init_en = 1; init_data = 9'($urandom); a_en = 1; a_data = 9'($urandom); wr_done = i[0];
      #3;
      checks++; if (lcd_en !== 1'b1 || lcd_data !== init_data) begin
        errors++; $display("FAIL init_path: got en=%b data=%h want en=1 data=%h", lcd_en, lcd_data, init_data); end
      checks++; if (a_gnt !== 1'b0 || a_wr_done !== 1'b0) begin
        errors++; $display("FAIL init_a_blocked: got gnt=%b done=%b want 0 0", a_gnt, a_wr_done); end
      checks++; if (init_wr_done !== wr_done) begin
        errors++; $display("FAIL init_done_route: got %b want %b", init_wr_done, wr_done); end
    end
    tick();
    init_done = 1; wr_done = 0;
    #3;
    k = 0; bad = 0;
    while (a_gnt !== 1'b1 && k < 50) begin
      tick();
      wr_done = 1;
      k++;
      #3;
      if (a_gnt !== 1'b1 && (lcd_en !== 1'b0 || init_wr_done !== 1'b0)) bad = 1;
    end
    wr_done = 0;
    checks++; if (k != GAP + 2) begin errors++; $display("FAIL init_to_a_latency: got %0d want %0d", k, GAP + 2); end
    checks++; if (bad) begin errors++; $display("FAIL init_ignored_after_done: got active init path want idle"); end
  endtask

  task automatic test_tie_break();
    int k, low;
    bit bad;
    do_reset();
    do_init();
    a_en = 1; b_en = 1; a_data = 9'($urandom); b_data = 9'($urandom);
    #3;
    checks++; if ({a_gnt, b_gnt} !== 2'b00) begin errors++; $display("FAIL tie_idle: got %b want 00", {a_gnt, b_gnt}); end
    tick(); #3;
    checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || lcd_data !== a_data) begin
      errors++; $display("FAIL tie_a_first: got a=%b b=%b data=%h want 1 0 %h", a_gnt, b_gnt, lcd_data, a_data); end
    repeat (2) tick();
    tick(); a_en = 0; #3;
    k = 0; low = 0; bad = 0;
    while (b_gnt !== 1'b1 && k < 50) begin
      tick(); k++; #3;
      if (b_gnt !== 1'b1) begin
        low++;
        if (lcd_en !== 1'b0) bad = 1;
      end
    end
    checks++; if (k != GAP + 2) begin errors++; $display("FAIL tie_b_latency: got %0d want %0d", k, GAP + 2); end
    checks++; if (bad || low < GAP) begin errors++; $display("FAIL tie_gap_low: got low=%0d bad=%b want >=%0d 0", low, bad, GAP); end
    checks++; if (lcd_data !== b_data || lcd_en !== 1'b1) begin
      errors++; $display("FAIL tie_b_data: got %h want %h", lcd_data, b_data); end
  endtask

  task automatic test_done_routing();
    int acnt, bcnt, k;
    bit bad;
    acnt = 0; bcnt = 0; bad = 0;
    a_en = 1;
    for (int i = 0; i < 28; i++) begin
      tick();
      wr_done = (i % 2 == 0);
      if (i % 2 == 1) b_data = 9'($urandom);
      #3;
      acnt += int'(a_wr_done);
      bcnt += int'(b_wr_done);
      if (lcd_data !== b_data || lcd_en !== 1'b1 || b_gnt !== 1'b1) bad = 1;
    end
    wr_done = 0;
    checks++; if (bcnt != 14) begin errors++; $display("FAIL route_b_count: got %0d want 14", bcnt); end
    checks++; if (acnt != 0) begin errors++; $display("FAIL route_a_count: got %0d want 0", acnt); end
    checks++; if (bad) begin errors++; $display("FAIL route_b_path: got wrong data/grant want b owner"); end
    tick(); b_en = 0; #3;
    k = 0;
    while (a_gnt !== 1'b1 && k < 50) begin tick(); k++; #3; end
    checks++; if (k != GAP + 2) begin errors++; $display("FAIL route_a_after_b: got %0d want %0d", k, GAP + 2); end
  endtask

  task automatic test_drop_with_done();
    tick(); a_data = 9'($urandom); #3;
    tick(); a_en = 0; wr_done = 1; #3;
    checks++; if (a_wr_done !== 1'b1 || a_gnt !== 1'b1 || b_wr_done !== 1'b0) begin
      errors++; $display("FAIL drop_done_routed: got a_done=%b gnt=%b b_done=%b want 1 1 0", a_wr_done, a_gnt, b_wr_done); end
    tick(); wr_done = 0; #3;
    checks++; if (a_gnt !== 1'b0 || lcd_en !== 1'b0 || a_wr_done !== 1'b0) begin
      errors++; $display("FAIL drop_to_gap: got gnt=%b en=%b done=%b want 0 0 0", a_gnt, lcd_en, a_wr_done); end
  endtask

  task automatic test_watchdog();
    int errcnt, errpos, bpos, alast;
    bit a_hole;
    errcnt = 0; errpos = -1; bpos = -1; alast = -1; a_hole = 0;
    repeat (GAP) tick();
    a_en = 1; a_data = 9'($urandom);
    for (int k = 0; k < WD + GAP + 10; k++) begin
      tick();
      if (k == 1) begin b_en = 1; b_data = 9'($urandom); end
      #3;
      if (arb_err === 1'b1) begin errcnt++; errpos = k; end
      if (b_gnt === 1'b1 && bpos < 0) bpos = k;
      if (a_gnt === 1'b1) begin
        if (alast != k - 1) a_hole = 1;
        alast = k;
      end
    end
`ifdef LCD_ARB_WDOG_EN
    checks++; if (errcnt != 1 || errpos != WD - 1) begin
      errors++; $display("FAIL wdog_err_pulse: got cnt=%0d pos=%0d want 1 %0d", errcnt, errpos, WD - 1); end
    checks++; if (alast != WD - 1 || a_hole) begin errors++; $display("FAIL wdog_a_drop: got last=%0d want %0d", alast, WD - 1); end
    checks++; if (bpos != WD + GAP + 1) begin errors++; $display("FAIL wdog_b_grant: got %0d want %0d", bpos, WD + GAP + 1); end
    tick(); b_en = 0;
    repeat (GAP + 3) tick();
    #3;
    checks++; if (a_gnt !== 1'b0) begin errors++; $display("FAIL wdog_a_blocked: got %b want 0", a_gnt); end
`else
    checks++; if (errcnt != 0) begin errors++; $display("FAIL nowdog_err: got %0d want 0", errcnt); end
    checks++; if (alast != WD + GAP + 9 || a_hole) begin
      errors++; $display("FAIL nowdog_a_held: got last=%0d want %0d", alast, WD + GAP + 9); end
    checks++; if (bpos != -1) begin errors++; $display("FAIL nowdog_b_wait: got %0d want -1", bpos); end
`endif
    clr_in();
  endtask

  task automatic test_async_reset();
    do_reset();
    do_init();
    b_en = 1; b_data = 9'($urandom);
    repeat (2) tick();
    #3;
    checks++; if (b_gnt !== 1'b1 || lcd_en !== 1'b1) begin
      errors++; $display("FAIL arst_pre: got gnt=%b en=%b want 1 1", b_gnt, lcd_en); end
    #1 rst_n = 0; init_en = 1; init_data = 9'($urandom);
    #1;
    checks++; if (lcd_en !== 1'b0 || b_gnt !== 1'b0 || lcd_data !== 9'h000) begin
      errors++; $display("FAIL arst_drop: got en=%b gnt=%b data=%h want 0 0 000", lcd_en, b_gnt, lcd_data); end
    #2 rst_n = 1;
    #1;
    checks++; if (lcd_en !== 1'b1 || lcd_data !== init_data || b_gnt !== 1'b0) begin
      errors++; $display("FAIL arst_init_back: got en=%b data=%h gnt=%b want 1 %h 0", lcd_en, lcd_data, b_gnt, init_data); end
    clr_in();
  endtask

  // reference: owner plus the cycle from which arbitration may next pick
  task automatic test_random();
    int owner, idle_from, a_need, b_need, a_got, b_got;
    bit last_a;
    logic [13:0] exp_v, got_v;
    do_reset();
    do_init();
    owner = 0; idle_from = 0; last_a = 0;
    a_need = 1; b_need = 1; a_got = 0; b_got = 0;
    for (int c = 0; c < 400; c++) begin
      if (c > 0) tick();
      if (!a_en) begin
        if ($urandom_range(0, 7) == 0) begin a_en = 1; a_need = $urandom_range(1, 4); a_got = 0; end
      end else if (owner == 1 && a_got >= a_need) a_en = 0;
      if (!b_en) begin
        if ($urandom_range(0, 7) == 0) begin b_en = 1; b_need = $urandom_range(1, 4); b_got = 0; end
      end else if (owner == 2 && b_got >= b_need) b_en = 0;
      a_data = 9'($urandom); b_data = 9'($urandom);
      init_en = 1'($urandom); init_data = 9'($urandom);
      wr_done = ($urandom_range(0, 2) == 0);
      #3;
      exp_v = {owner == 1, owner == 2,
               (owner == 1) ? a_en : (owner == 2) ? b_en : 1'b0,
               (owner == 1) ? a_data : (owner == 2) ? b_data : 9'h000,
               owner == 1 && wr_done, owner == 2 && wr_done, 1'b0};
      got_v = {a_gnt, b_gnt, lcd_en, lcd_data, a_wr_done, b_wr_done, init_wr_done};
      checks++;
      if (got_v !== exp_v || arb_err !== 1'b0) begin
        errors++; $display("FAIL rand_cycle%0d: got %h err=%b want %h err=0", c, got_v, arb_err, exp_v);
      end
      if (owner == 1) begin
        if (wr_done) a_got++;
        if (!a_en) begin owner = 0; last_a = 1; idle_from = c + 1 + GAP; end
      end else if (owner == 2) begin
        if (wr_done) b_got++;
        if (!b_en) begin owner = 0; last_a = 0; idle_from = c + 1 + GAP; end
      end else if (c >= idle_from) begin
        if (a_en && (!b_en || !last_a)) owner = 1;
        else if (b_en)                  owner = 2;
      end
    end
    clr_in();
  endtask

  initial begin
    clr_in();
    test_reset();
    test_init_ownership();
    test_tie_break();
    test_done_routing();
    test_drop_with_done();
    test_watchdog();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_wr_arbiter.md
# lcd_wr_arbiter

Shares the single 9-bit LCD serial writer between the power-up initialisation sequencer and two display-content requesters: temperature digits (A) and static labels/frames (B). The initialisation source owns the writer exclusively until its `init_done` rises. After that, A and B are granted whole bursts in round-robin order, separated by an idle gap. Each `wr_done` pulse from the writer is routed back only to the current owner.

## Interface
Parameters:
- `GAP_CYCLES`, default 4: idle cycles with `lcd_en` low between bursts (minimum 1).
- `WDOG_CYCLES`, default 23'd5_000_000: cycles without `wr_done` after which a display grant is revoked (100 ms at 50 MHz).

Ports (one clock; reset is asynchronous and active-low):
- `sys_clk_50MHz` in 1: system clock.
- `sys_rst_n` in 1: asynchronous active-low reset.
- `init_en` in 1: init sequencer write request.
- `init_data` in 9: init word; bit 8 = 1 data, 0 command.
- `init_done` in 1: init sequence complete (sticky in source).
- `a_en` in 1: requester A burst request; held high for the whole burst.
- `a_data` in 9: requester A word.
- `b_en` in 1: requester B burst request.
- `b_data` in 9: requester B word.
- `wr_done` in 1: writer finished current word; 1-cycle pulse.
- `lcd_en` out 1: write enable to the writer.
- `lcd_data` out 9: word to the writer.
- `a_wr_done` out 1: `wr_done` routed to A.
- `b_wr_done` out 1: `wr_done` routed to B.
- `a_gnt` out 1: A owns the writer.
- `b_gnt` out 1: B owns the writer.
- `init_wr_done` out 1: `wr_done` routed to the init sequencer.
- `arb_err` out 1: watchdog revoke; 1-cycle pulse.

## Operation
- FSM states: `ST_INIT`, `ST_IDLE`, `ST_A`, `ST_B`, `ST_GAP`. Registered and one-hot.
- `ST_INIT`:
  - `lcd_en = init_en`, `lcd_data = init_data`, `init_wr_done = wr_done`.
  - A and B requests stay pending and receive no done pulses.
  - `init_done` is latched into `init_done_q`. On the cycle after it is first seen high, go to `ST_GAP`.
  - After that the init source is ignored permanently until reset.
- `ST_IDLE`:
  - Only A requesting → `ST_A`. Only B requesting → `ST_B`.
  - Both requesting → the requester not served last. `last_gnt` resets to B, so A wins the first tie.
  - Neither requesting → stay.
- `ST_A` / `ST_B`:
  - `lcd_en = x_en`, `lcd_data = x_data`, `x_wr_done = wr_done`.
  - Burst ends when the owner drops `x_en`. If that happens in the same cycle as `wr_done`, the done pulse is still routed to the owner. Then → `ST_GAP` and update `last_gnt`.
- `ST_GAP`: count `GAP_CYCLES`, then → `ST_IDLE`. `lcd_en = 0`.
- Outside a grant, `lcd_data = 9'h000` and all `*_wr_done = 0`.
- A `wr_done` arriving with no owner (`ST_IDLE`/`ST_GAP`) is dropped.
- Gap counter width is `$clog2(GAP_CYCLES+1)`. It is cleared on entry to `ST_GAP` and never wraps.

## Timing
- Reset values: `lcd_en` 0, `lcd_data` 9'h000, all `*_wr_done` 0, `a_gnt`/`b_gnt` 0, `arb_err` 0, state `ST_INIT`.
- Outputs are a combinational mux driven by the registered state; there is no extra register stage.
- Data path: `lcd_data` and `lcd_en` follow the owner's inputs in the same cycle.
- `wr_done` routing is combinational with zero latency.
- Arbitration latency:
  - Request seen in `ST_IDLE` at cycle n → grant visible at n+1.
  - Back-to-back bursts: release at n → next grant no earlier than n+1+`GAP_CYCLES`+1.
- Reset asserted mid-burst: all outputs drop immediately (asynchronously) and the FSM restarts in `ST_INIT`. An in-flight writer word is abandoned.
- Requesters must hold `x_data` stable until their `x_wr_done`. The arbiter does not buffer words.

## Configuration
- Macro `LCD_ARB_WDOG_EN`.
- Defined:
  - A watchdog counter runs in `ST_A`/`ST_B`. It is cleared on grant entry and on every `wr_done`.
  - When it reaches `WDOG_CYCLES`: force → `ST_GAP`, pulse `arb_err` for one cycle, update `last_gnt`.
  - The revoked requester sees its grant drop. It must deassert `x_en` before it can be re-granted; a still-high `x_en` is treated as a new request only after it falls.
  - `ST_INIT` is never watchdogged.
- Undefined: no counter; `arb_err` tied 0; grants end only on `x_en` fall.

## Structure
- Shared package `lcd_pkg`:
  - FSM state encoding.
  - 9-bit LCD word typedef (cmd/data flag + byte).
  - `DATA_IDLE` = 9'h000.
- One natural sub-module, `lcd_arb_wdog`: the watchdog counter with clear/expire. It is instantiated only under `LCD_ARB_WDOG_EN`.

## Test plan
- **Init ownership:** `init_en=1`, `a_en=1` before `init_done`. Required: `lcd_data` tracks `init_data`, `a_wr_done` stays 0, `a_gnt` stays 0. After `init_done`, A is granted 1+`GAP_CYCLES`+1 cycles later.
- **Tie-break:** after init, raise A and B in the same cycle. Required: A granted first. After A drops, B is granted following a 4-cycle gap with `lcd_en` low.
- **Done routing:** during a B burst of 14 words, 14 `wr_done` pulses. Required: 14 `b_wr_done` pulses, 0 `a_wr_done` pulses.
- **Drop with done:** A drops `a_en` in the same cycle as `wr_done`. Required: `a_wr_done` = 1 on that cycle, then `ST_GAP`.
- **Watchdog (macro on, `WDOG_CYCLES`=100):** A granted and no `wr_done` for 100 cycles. Required: `arb_err` pulses once, `a_gnt` falls, and a pending B is granted after the gap.
- **Async reset mid-burst:** reset asserted during a B burst. Required: `lcd_en`=0 and `b_gnt`=0 immediately. After release, `init_en` regains the writer.
